// File: rtl/vx_raster_qe_sched.sv
// vx_raster_qe_sched: walks one block's quads in raster order through a 1-stage QE, dropping all-miss batches.
module vx_raster_qe_sched #(
  parameter string INSTANCE_ID   = "",
  parameter int    NUM_QUADS     = 4,
  parameter int    BLOCK_LOGSIZE = 3,
  parameter int    PID_BITS      = 16,
  parameter int    DIM_BITS      = 16,
  parameter int    DATA_BITS     = 32
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              valid_in,
  output logic                                              ready_in,
  input  logic [PID_BITS-1:0]                               pid_in,
  input  logic [DIM_BITS-1:0]                               xloc_in,
  input  logic [DIM_BITS-1:0]                               yloc_in,
  input  logic [DIM_BITS-1:0]                               xmin_in,
  input  logic [DIM_BITS-1:0]                               xmax_in,
  input  logic [DIM_BITS-1:0]                               ymin_in,
  input  logic [DIM_BITS-1:0]                               ymax_in,
  input  logic [2:0][2:0][DATA_BITS-1:0]                    edges_in,
  output logic                                              qe_enable,
  output logic                                              qe_valid,
  output logic [PID_BITS-1:0]                               qe_pid,
  output logic [NUM_QUADS-1:0][DIM_BITS-1:0]                qe_xloc,
  output logic [NUM_QUADS-1:0][DIM_BITS-1:0]                qe_yloc,
  output logic [DIM_BITS-1:0]                               qe_xmin,
  output logic [DIM_BITS-1:0]                               qe_xmax,
  output logic [DIM_BITS-1:0]                               qe_ymin,
  output logic [DIM_BITS-1:0]                               qe_ymax,
  output logic [NUM_QUADS-1:0][2:0][2:0][DATA_BITS-1:0]     qe_edges,
  input  logic                                              qe_valid_out,
  input  logic [NUM_QUADS-1:0]                              qe_overlap,
  output logic                                              valid_out,
  input  logic                                              ready_out,
  output logic                                              block_done
);
  localparam int QS  = 1 << (BLOCK_LOGSIZE - 1);
  localparam int QPB = QS * QS;
  localparam int NB  = QPB / NUM_QUADS;
  localparam int BW  = NB > 1 ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST = BW'(NB - 1);

  typedef enum logic {IDLE, WALK} state_t;
  state_t r_state, w_next;
  logic [BW-1:0]                  r_batch;
  logic                           r_last;
  logic [PID_BITS-1:0]            r_pid;
  logic [DIM_BITS-1:0]            r_x0, r_y0, r_xmin, r_xmax, r_ymin, r_ymax;
  logic [2:0][2:0][DATA_BITS-1:0] r_edges;
  logic [NUM_QUADS-1:0][DIM_BITS-1:0] w_dx, w_dy;
  logic w_accept, w_last_batch;

  assign w_accept     = valid_in && ready_in;
  assign w_last_batch = r_batch == LAST;

  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = valid_in ? WALK : IDLE;
    else                 w_next = (qe_enable && w_last_batch) ? IDLE : WALK;
  end

  always_comb begin
    ready_in   = !reset && r_state == IDLE;
    qe_valid   = r_state == WALK;
    valid_out  = qe_valid_out && |qe_overlap;
    qe_enable  = !(valid_out && !ready_out);
    block_done = qe_valid_out && r_last && qe_enable;
  end

  // last_q moves in lockstep with the QE stage so block_done lines up with its output
  always_ff @(posedge clk)
    if (reset) begin
      r_batch <= '0;
      r_last  <= 1'b0;
    end else begin
      if (w_accept) r_batch <= '0;
      else if (r_state == WALK && qe_enable) r_batch <= w_last_batch ? '0 : r_batch + 1'b1;
      if (qe_enable) r_last <= r_state == WALK && w_last_batch;
    end

  always_ff @(posedge clk)
    if (w_accept) begin
      r_pid   <= pid_in;
      r_x0    <= xloc_in;
      r_y0    <= yloc_in;
      r_xmin  <= xmin_in;
      r_xmax  <= xmax_in;
      r_ymin  <= ymin_in;
      r_ymax  <= ymax_in;
      r_edges <= edges_in;
    end

  assign qe_pid  = r_pid;
  assign qe_xmin = r_xmin;
  assign qe_xmax = r_xmax;
  assign qe_ymin = r_ymin;
  assign qe_ymax = r_ymax;

  for (genvar q = 0; q < NUM_QUADS; q++) begin : g_quad
    assign w_dx[q]    = DIM_BITS'(2 * ((int'(r_batch) * NUM_QUADS + q) % QS));
    assign w_dy[q]    = DIM_BITS'(2 * ((int'(r_batch) * NUM_QUADS + q) / QS));
    assign qe_xloc[q] = r_x0 + w_dx[q];
    assign qe_yloc[q] = r_y0 + w_dy[q];
    for (genvar k = 0; k < 3; k++) begin : g_edge
      assign qe_edges[q][k][0] = r_edges[k][0];
      assign qe_edges[q][k][1] = r_edges[k][1];
      assign qe_edges[q][k][2] = r_edges[k][2] + r_edges[k][0] * DATA_BITS'(w_dx[q])
                                               + r_edges[k][1] * DATA_BITS'(w_dy[q]);
    end
  end
endmodule

// File: tb/tb_vx_raster_qe_sched.sv
// tb_vx_raster_qe_sched: directed bench with a 1-stage bbox-test QE model and a downstream monitor.
module tb_vx_raster_qe_sched;
  logic clk = 0, reset = 1, valid_in = 0, ready_in, ready_out = 1;
  logic [15:0] pid_in = 0, xloc_in = 0, yloc_in = 0, xmin_in = 0, xmax_in = 0, ymin_in = 0, ymax_in = 0;
  logic [2:0][2:0][31:0] edges_in;
  logic qe_enable, qe_valid, qe_valid_out, valid_out, block_done;
  logic [15:0] qe_pid, qe_xmin, qe_xmax, qe_ymin, qe_ymax;
  logic [3:0][15:0] qe_xloc, qe_yloc;
  logic [3:0][2:0][2:0][31:0] qe_edges;
  logic [3:0] qe_overlap;
  logic [15:0] r_qy0;
  logic [15:0] seen[$];
  int n_done = 0, checks = 0, failures = 0;

  vx_raster_qe_sched dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in), .pid_in(pid_in),
    .xloc_in(xloc_in), .yloc_in(yloc_in), .xmin_in(xmin_in), .xmax_in(xmax_in),
    .ymin_in(ymin_in), .ymax_in(ymax_in), .edges_in(edges_in), .qe_enable(qe_enable),
    .qe_valid(qe_valid), .qe_pid(qe_pid), .qe_xloc(qe_xloc), .qe_yloc(qe_yloc),
    .qe_xmin(qe_xmin), .qe_xmax(qe_xmax), .qe_ymin(qe_ymin), .qe_ymax(qe_ymax),
    .qe_edges(qe_edges), .qe_valid_out(qe_valid_out), .qe_overlap(qe_overlap),
    .valid_out(valid_out), .ready_out(ready_out), .block_done(block_done)
  );

  always #5 clk = ~clk;

  // stand-in QE: one enabled register stage, overlap = quad origin inside bbox
  always @(posedge clk)
    if (reset) begin
      qe_valid_out <= 0;
      qe_overlap   <= 0;
      r_qy0        <= 0;
    end else if (qe_enable) begin
      qe_valid_out <= qe_valid;
      r_qy0        <= qe_yloc[0];
      for (int q = 0; q < 4; q++)
        qe_overlap[q] <= qe_valid && qe_xloc[q] >= qe_xmin && qe_xloc[q] < qe_xmax
                         && qe_yloc[q] >= qe_ymin && qe_yloc[q] < qe_ymax;
    end

  always @(negedge clk) begin
    if (valid_out && ready_out) seen.push_back(r_qy0);
    if (block_done) n_done++;
  end

  typedef struct {
    logic [15:0] x0, x3, y0;
    logic [31:0] c0q0, c0q3, c1q3, c2q2;
  } vec_t;
  vec_t tbl[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_edges();
    edges_in[0][0] = 1; edges_in[0][1] = 2; edges_in[0][2] = 0;
    edges_in[1][0] = 3; edges_in[1][1] = 5; edges_in[1][2] = 100;
    edges_in[2][0] = 0; edges_in[2][1] = 1; edges_in[2][2] = 7;
  endtask

  task automatic start_block(input logic [15:0] xmx, input logic [15:0] ymx);
    pid_in = 16'h2a; xloc_in = 16; yloc_in = 8;
    xmin_in = 0; xmax_in = xmx; ymin_in = 0; ymax_in = ymx;
    valid_in = 1;
    for (int i = 0; i < 20 && !ready_in; i++) step();
    chk("accept_ready", ready_in, 1);
    step();
    valid_in = 0;
  endtask

  task automatic wait_done(input int max);
    int b = n_done;
    for (int i = 0; i < max && n_done == b; i++) step();
    chk("done_timeout", n_done != b, 1);
  endtask

  initial begin
    int bd, sq;
    for (int b = 0; b < 4; b++) begin
      tbl[b].x0   = 16;
      tbl[b].x3   = 22;
      tbl[b].y0   = 16'(8 + 2 * b);
      tbl[b].c0q0 = 32'(4 * b);
      tbl[b].c0q3 = 32'(6 + 4 * b);
      tbl[b].c1q3 = 32'(118 + 10 * b);
      tbl[b].c2q2 = 32'(7 + 2 * b);
    end
    set_edges();
    step();
    chk("rst_ready_in", ready_in, 0);
    chk("rst_qe_valid", qe_valid, 0);
    chk("rst_block_done", block_done, 0);
    step();
    chk("rst_ready_in2", ready_in, 0);
    reset = 0;
    #1;
    chk("post_rst_ready", ready_in, 1);

    bd = n_done; sq = seen.size();
    start_block(64, 64);
    chk("pid_latched", qe_pid, 16'h2a);
    for (int b = 0; b < 4; b++) begin
      chk("walk_qe_valid", qe_valid, 1);
      chk("walk_ready_in", ready_in, 0);
      chk("qe_out_latency", qe_valid_out, b > 0);
      chk("xloc_q0", qe_xloc[0], tbl[b].x0);
      chk("xloc_q3", qe_xloc[3], tbl[b].x3);
      chk("yloc_q0", qe_yloc[0], tbl[b].y0);
      chk("c0_q0", qe_edges[0][0][2], tbl[b].c0q0);
      chk("c0_q3", qe_edges[3][0][2], tbl[b].c0q3);
      chk("c1_q3", qe_edges[3][1][2], tbl[b].c1q3);
      chk("c2_q2", qe_edges[2][2][2], tbl[b].c2q2);
      chk("a1_pass", qe_edges[3][1][0], 3);
      chk("b1_pass", qe_edges[3][1][1], 5);
      step();
    end
    chk("end_block_done", block_done, 1);
    chk("end_valid_out", valid_out, 1);
    chk("end_ready_in", ready_in, 1);
    chk("end_qe_valid", qe_valid, 0);
    step();
    chk("done_pulse_1cyc", block_done, 0);
    chk("main_done_cnt", n_done - bd, 1);
    chk("main_batch_cnt", seen.size() - sq, 4);
    for (int i = 0; i < 4 && sq + i < seen.size(); i++) chk("main_order", seen[sq + i], 16'(8 + 2 * i));

    bd = n_done; sq = seen.size();
    start_block(0, 0);
    wait_done(20);
    repeat (3) step();
    chk("empty_no_valid", seen.size() - sq, 0);
    chk("empty_done_cnt", n_done - bd, 1);

    bd = n_done; sq = seen.size();
    start_block(64, 64);
    step();
    step();
    chk("stall_pre_valid", valid_out, 1);
    ready_out = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_enable", qe_enable, 0);
      chk("stall_yloc", qe_yloc[0], 12);
      chk("stall_xloc", qe_xloc[1], 18);
      step();
    end
    ready_out = 1;
    wait_done(20);
    repeat (2) step();
    chk("stall_done_cnt", n_done - bd, 1);
    chk("stall_batch_cnt", seen.size() - sq, 4);
    for (int i = 0; i < 4 && sq + i < seen.size(); i++) chk("stall_order", seen[sq + i], 16'(8 + 2 * i));

    edges_in[0][0] = 1; edges_in[0][1] = 0; edges_in[0][2] = 32'hFFFF_FFFE;
    start_block(64, 64);
    chk("wrap_q0", qe_edges[0][0][2], 32'hFFFF_FFFE);
    chk("wrap_q1", qe_edges[1][0][2], 0);
    chk("wrap_q3", qe_edges[3][0][2], 4);
    wait_done(20);
    repeat (2) step();
    set_edges();

    bd = n_done;
    start_block(64, 64);
    step();
    step();
    chk("mid_yloc_b2", qe_yloc[0], 12);
    reset = 1;
    #1;
    chk("mid_rst_ready", ready_in, 0);
    step();
    reset = 0;
    #1;
    chk("mid_rst_idle_qv", qe_valid, 0);
    chk("mid_rst_ready_in", ready_in, 1);
    chk("mid_rst_no_done", block_done, 0);
    repeat (6) step();
    chk("mid_rst_done_cnt", n_done - bd, 0);

    bd = n_done; sq = seen.size();
    start_block(64, 64);
    wait_done(20);
    repeat (2) step();
    chk("after_rst_done", n_done - bd, 1);
    chk("after_rst_batches", seen.size() - sq, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
